// File: rtl/token_ctrl_pkg.sv
// Shared types, width helpers and mode constants for the token controller.
package token_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    AX_WAIT,
    NR_WAIT,
    INT_READ,
    INT_CALC,
    INT_WB,
    LK_READ,
    LK_CALC,
    LK_SPIKE,
    LK_WB
  } state_t;

  localparam bit LEAK_MODE_OFF = 1'b0;
  localparam bit LEAK_MODE_ON  = 1'b1;

  // Index width for n entries, floored at 1 so single-entry configs stay legal.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned instr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit is_sweep_state(input state_t s);
    return (s == LK_READ) || (s == LK_CALC) || (s == LK_SPIKE) || (s == LK_WB);
  endfunction

endpackage

// File: rtl/token_controller_tick_instr_table.sv
// Per-axon weight-instruction register file: one write port, one async read port.
module instr_table
  import token_ctrl_pkg::*;
#(
  parameter  int unsigned DEPTH = 256,
  parameter  int unsigned DW    = 2,
  localparam int unsigned AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata_c
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reading the array directly gives old data on a same-cycle write.
  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/token_controller_tick.sv
// Token controller: sequences per-axon CSRAM read-modify-write and the tick-driven
// leak/threshold sweep, emitting spikes over a stallable valid/ready handshake.
module token_controller_tick
  import token_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_AXONS   = 256,
  parameter  int unsigned NUM_NEURONS = 256,
  parameter  int unsigned NUM_WEIGHTS = 4,
  parameter  bit          LEAK_ENABLE = LEAK_MODE_ON,
  localparam int unsigned AW          = addr_width(NUM_AXONS),
  localparam int unsigned NW          = addr_width(NUM_NEURONS),
  localparam int unsigned IW          = instr_width(NUM_WEIGHTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [IW-1:0] cfg_data,
  input  logic          decoder_empty,
  output logic          read_spike,
  input  logic [AW-1:0] axon_number_in,
  input  logic          axon_number_valid,
  output logic [AW-1:0] axon_number_out,
  input  logic [NW-1:0] neuron_number_in,
  input  logic          neuron_number_valid,
  input  logic          synap_done,
  output logic          CSRAM_write,
  output logic [NW-1:0] CSRAM_addr,
  output logic [IW-1:0] neuron_instruction,
  output logic          neuron_reg_en,
  output logic          integrate_en,
  output logic          leak_en,
  input  logic          spike_in,
  output logic          spike_out_valid,
  input  logic          spike_out_ready,
  output logic [NW-1:0] spike_out_neuron,
  output logic          busy,
  output logic          tick_overrun
);

  state_t        r_state,        w_next_state;
  logic          r_tick_pending, w_tick_pending;
  logic [AW-1:0] r_axon,         w_axon;
  logic [NW-1:0] r_addr,         w_addr;
  logic [NW-1:0] r_spike_neuron, w_spike_neuron;
  logic [IW-1:0] r_instr,        w_instr;
  logic          r_read_spike,   w_read_spike;
  logic          r_csram_write,  w_csram_write;
  logic          r_reg_en,       w_reg_en;
  logic          r_int_en,       w_int_en;
  logic          r_leak_en,      w_leak_en;
  logic          r_spike_valid,  w_spike_valid;
  logic          r_busy,         w_busy;
  logic          r_overrun,      w_overrun;
  logic          w_sweep_start;
  logic          w_tick_extra;
  logic [IW-1:0] w_table_rd;

  instr_table #(
    .DEPTH (NUM_AXONS),
    .DW    (IW)
  ) u_instr_table (
    .clk       (clk),
    .rst_n     (rst),
    .i_we      (cfg_we),
    .i_waddr   (cfg_addr),
    .i_wdata   (cfg_data),
    .i_raddr   (r_axon),
    .o_rdata_c (w_table_rd)
  );

  // Next state plus next value of every registered output, aligned to the next state.
  always_comb begin
    w_next_state   = r_state;
    w_axon         = r_axon;
    w_addr         = r_addr;
    w_spike_neuron = r_spike_neuron;
    w_sweep_start  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (r_tick_pending) begin
          w_next_state  = LK_READ;
          w_addr        = '0;
          w_sweep_start = 1'b1;
        end else if (!decoder_empty) begin
          w_next_state = AX_WAIT;
        end
      end
      AX_WAIT: begin
        if (axon_number_valid) begin
          w_axon       = axon_number_in;
          w_next_state = NR_WAIT;
        end
      end
      NR_WAIT: begin
        if (synap_done) begin
          w_next_state = IDLE;
        end else if (neuron_number_valid) begin
          w_addr       = neuron_number_in;
          w_next_state = INT_READ;
        end
      end
      INT_READ: w_next_state = INT_CALC;
      INT_CALC: w_next_state = INT_WB;
      INT_WB:   w_next_state = NR_WAIT;
      LK_READ:  w_next_state = LK_CALC;
      LK_CALC: begin
        if (spike_in) begin
          w_spike_neuron = r_addr;
          w_next_state   = LK_SPIKE;
        end else begin
          w_next_state = LK_WB;
        end
      end
      LK_SPIKE: begin
        if (spike_out_ready) begin
          w_next_state = LK_WB;
        end
      end
      LK_WB: begin
        if (r_addr == NW'(NUM_NEURONS - 1)) begin
          w_addr       = '0;
          w_next_state = IDLE;
        end else begin
          w_addr       = r_addr + NW'(1);
          w_next_state = LK_READ;
        end
      end
      default: w_next_state = IDLE;
    endcase

    w_read_spike  = (r_state == IDLE) && (w_next_state == AX_WAIT);
    w_csram_write = (w_next_state == INT_WB) || (w_next_state == LK_WB);
    w_reg_en      = (w_next_state == INT_READ) || (w_next_state == INT_CALC) ||
                    (w_next_state == LK_READ);
    w_int_en      = (w_next_state == INT_CALC);
    w_instr       = (w_next_state == INT_CALC) ? w_table_rd : '0;
    w_leak_en     = (w_next_state == LK_CALC) && LEAK_ENABLE;
    w_spike_valid = (w_next_state == LK_SPIKE);
    w_busy        = (w_next_state != IDLE);

    // A tick is surplus if one is already queued or a sweep is in flight.
    w_tick_extra   = tick && (r_tick_pending || is_sweep_state(r_state));
    w_overrun      = r_overrun || w_tick_extra;
    w_tick_pending = r_tick_pending;
    if (w_sweep_start) begin
      w_tick_pending = 1'b0;
    end
    if (tick && !w_tick_extra) begin
      w_tick_pending = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_tick_pending <= 1'b0;
      r_axon         <= '0;
      r_addr         <= '0;
      r_spike_neuron <= '0;
      r_instr        <= '0;
      r_read_spike   <= 1'b0;
      r_csram_write  <= 1'b0;
      r_reg_en       <= 1'b0;
      r_int_en       <= 1'b0;
      r_leak_en      <= 1'b0;
      r_spike_valid  <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_tick_pending <= w_tick_pending;
      r_axon         <= w_axon;
      r_addr         <= w_addr;
      r_spike_neuron <= w_spike_neuron;
      r_instr        <= w_instr;
      r_read_spike   <= w_read_spike;
      r_csram_write  <= w_csram_write;
      r_reg_en       <= w_reg_en;
      r_int_en       <= w_int_en;
      r_leak_en      <= w_leak_en;
      r_spike_valid  <= w_spike_valid;
      r_busy         <= w_busy;
      r_overrun      <= w_overrun;
    end
  end

  assign read_spike         = r_read_spike;
  assign axon_number_out    = r_axon;
  assign CSRAM_write        = r_csram_write;
  assign CSRAM_addr         = r_addr;
  assign neuron_instruction = r_instr;
  assign neuron_reg_en      = r_reg_en;
  assign integrate_en       = r_int_en;
  assign leak_en            = r_leak_en;
  assign spike_out_valid    = r_spike_valid;
  assign spike_out_neuron   = r_spike_neuron;
  assign busy               = r_busy;
  assign tick_overrun       = r_overrun;

endmodule

// File: tb/tb_token_controller_tick.sv
// Scoreboard bench for token_controller_tick: 16 axons, 8 neurons, 4 weights, leak on.
module tb_token_controller_tick;

  localparam int unsigned NA  = 16;
  localparam int unsigned NN  = 8;
  localparam int unsigned NWT = 4;
  localparam int unsigned AW  = 4;
  localparam int unsigned NW  = 3;
  localparam int unsigned IW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [IW-1:0] cfg_data;
  logic          decoder_empty;
  logic          read_spike;
  logic [AW-1:0] axon_number_in;
  logic          axon_number_valid;
  logic [AW-1:0] axon_number_out;
  logic [NW-1:0] neuron_number_in;
  logic          neuron_number_valid;
  logic          synap_done;
  logic          CSRAM_write;
  logic [NW-1:0] CSRAM_addr;
  logic [IW-1:0] neuron_instruction;
  logic          neuron_reg_en;
  logic          integrate_en;
  logic          leak_en;
  logic          spike_in = 1'b0;
  logic          spike_out_valid;
  logic          spike_out_ready;
  logic [NW-1:0] spike_out_neuron;
  logic          busy;
  logic          tick_overrun;

  int checks = 0;
  int errors = 0;

  logic [NW-1:0] exp_wr  [$];
  logic [IW-1:0] exp_ins [$];
  logic [NW-1:0] exp_sp  [$];
  logic [NN-1:0] fire_mask  = '0;
  logic          prev_valid = 1'b0;
  logic [NW-1:0] m_wr;
  logic [IW-1:0] m_ins;
  logic [NW-1:0] m_sp;

  token_controller_tick #(
    .NUM_AXONS   (NA),
    .NUM_NEURONS (NN),
    .NUM_WEIGHTS (NWT),
    .LEAK_ENABLE (1'b1)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .tick                (tick),
    .cfg_we              (cfg_we),
    .cfg_addr            (cfg_addr),
    .cfg_data            (cfg_data),
    .decoder_empty       (decoder_empty),
    .read_spike          (read_spike),
    .axon_number_in      (axon_number_in),
    .axon_number_valid   (axon_number_valid),
    .axon_number_out     (axon_number_out),
    .neuron_number_in    (neuron_number_in),
    .neuron_number_valid (neuron_number_valid),
    .synap_done          (synap_done),
    .CSRAM_write         (CSRAM_write),
    .CSRAM_addr          (CSRAM_addr),
    .neuron_instruction  (neuron_instruction),
    .neuron_reg_en       (neuron_reg_en),
    .integrate_en        (integrate_en),
    .leak_en             (leak_en),
    .spike_in            (spike_in),
    .spike_out_valid     (spike_out_valid),
    .spike_out_ready     (spike_out_ready),
    .spike_out_neuron    (spike_out_neuron),
    .busy                (busy),
    .tick_overrun        (tick_overrun)
  );

  always #5 clk = ~clk;

  // Datapath model: threshold result for the neuron under leak.
  always @(negedge clk) spike_in = leak_en && fire_mask[CSRAM_addr];

  // Scoreboard: pop expected writes, instructions and spikes as the DUT produces them.
  always @(negedge clk) begin
    if (rst) begin
      if (CSRAM_write) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL csram_write unexpected: addr=%0d, none expected", CSRAM_addr);
        end else begin
          m_wr = exp_wr.pop_front();
          if (CSRAM_addr !== m_wr) begin
            errors++;
            $display("FAIL csram_write addr: got %0d want %0d", CSRAM_addr, m_wr);
          end
        end
      end
      if (integrate_en) begin
        checks++;
        if (exp_ins.size() == 0) begin
          errors++;
          $display("FAIL integrate unexpected: instr=%0d", neuron_instruction);
        end else begin
          m_ins = exp_ins.pop_front();
          if (neuron_instruction !== m_ins) begin
            errors++;
            $display("FAIL neuron_instruction: got %0d want %0d", neuron_instruction, m_ins);
          end
        end
      end
      if (spike_out_valid && !prev_valid) begin
        checks++;
        if (exp_sp.size() == 0) begin
          errors++;
          $display("FAIL spike unexpected: neuron=%0d", spike_out_neuron);
        end else begin
          m_sp = exp_sp.pop_front();
          if (spike_out_neuron !== m_sp) begin
            errors++;
            $display("FAIL spike_out_neuron: got %0d want %0d", spike_out_neuron, m_sp);
          end
        end
      end
    end
    prev_valid = spike_out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cfg_write(input logic [AW-1:0] a, input logic [IW-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Acts as decoder + synapse walker for one axon; neuron k is nl[k*NW +: NW].
  task automatic drive_axon(input logic [AW-1:0] ax, input logic [4*NW-1:0] nl,
                            input int cnt, input bit tick_in_calc, input bit done_with_valid,
                            output int cyc, output int rs_cnt, output bit to);
    int  k;
    int  guard;
    bit  seen;
    bit  tick_sent;
    cyc = 0; rs_cnt = 0; k = 0; guard = 0; seen = 0; tick_sent = 0;
    decoder_empty = 1'b0;
    while (!read_spike && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (read_spike) rs_cnt = 1;
    decoder_empty       = 1'b1;
    axon_number_in      = ax;
    axon_number_valid   = 1'b1;
    neuron_number_in    = nl[0 +: NW];
    neuron_number_valid = 1'b1;
    guard = 0;
    while (guard < 200) begin
      @(negedge clk);
      guard++;
      axon_number_valid = 1'b0;
      tick = 1'b0;
      if (read_spike) rs_cnt++;
      if (busy) begin
        seen = 1;
        cyc++;
      end else if (seen) begin
        break;
      end
      if (tick_in_calc && integrate_en && !tick_sent) begin
        tick      = 1'b1;
        tick_sent = 1;
      end
      if (CSRAM_write) begin
        k++;
        if (k < cnt) begin
          neuron_number_in = nl[k*NW +: NW];
        end else begin
          synap_done          = 1'b1;
          neuron_number_valid = done_with_valid;
          neuron_number_in    = NW'(2);
        end
      end
    end
    to = !(seen && !busy) || (rs_cnt == 0);
    synap_done          = 1'b0;
    neuron_number_valid = 1'b0;
    tick                = 1'b0;
  endtask

  // Waits out one sweep, stalling spike_out_ready and optionally injecting a tick.
  task automatic run_sweep(input int stall, input int tick_at, input bit send_tick,
                           output int bcyc, output int unstable, output int wr_in_stall,
                           output int lkc, output bit to);
    int            guard;
    int            stall_seen;
    bit            seen;
    logic [NW-1:0] held;
    bit            held_ok;
    bcyc = 0; unstable = 0; wr_in_stall = 0; lkc = 0; guard = 0;
    stall_seen = 0; seen = 0; held = '0; held_ok = 0;
    if (send_tick) tick = 1'b1;
    while (guard < 400) begin
      @(negedge clk);
      guard++;
      tick = 1'b0;
      if (busy) begin
        seen = 1;
        bcyc++;
      end else if (seen) begin
        break;
      end
      if (tick_at > 0 && bcyc == tick_at) tick = 1'b1;
      if (leak_en) lkc++;
      if (spike_out_valid) begin
        if (!held_ok) begin
          held    = spike_out_neuron;
          held_ok = 1;
        end else if (spike_out_neuron !== held) begin
          unstable++;
        end
        if (CSRAM_write) wr_in_stall++;
        if (stall_seen < stall) begin
          spike_out_ready = 1'b0;
          stall_seen++;
        end else begin
          spike_out_ready = 1'b1;
        end
      end else begin
        held_ok = 0;
      end
    end
    to = !(seen && !busy);
    tick = 1'b0;
    spike_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    decoder_empty = 1'b1; axon_number_in = '0; axon_number_valid = 1'b0;
    neuron_number_in = '0; neuron_number_valid = 1'b0; synap_done = 1'b0;
    spike_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset busy: got %b want 0", busy);
    end
    checks++;
    if ({read_spike, CSRAM_write, neuron_reg_en, integrate_en, leak_en, spike_out_valid,
         tick_overrun} !== 7'b0) begin
      errors++;
      $display("FAIL reset strobes: got %b want 0000000", {read_spike, CSRAM_write,
               neuron_reg_en, integrate_en, leak_en, spike_out_valid, tick_overrun});
    end
    checks++;
    if (CSRAM_addr !== '0 || axon_number_out !== '0 || spike_out_neuron !== '0 ||
        neuron_instruction !== '0) begin
      errors++;
      $display("FAIL reset buses: addr=%0d axon=%0d spk=%0d ins=%0d want all 0",
               CSRAM_addr, axon_number_out, spike_out_neuron, neuron_instruction);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || read_spike !== 1'b0) begin
      errors++; $display("FAIL idle_quiet: busy=%b read_spike=%b want 0 0", busy, read_spike);
    end
  endtask

  task automatic test_config_integrate();
    int cyc, rs;
    bit to;
    cfg_write(4'd5, 2'd2);
    cfg_write(4'd9, 2'd3);
    exp_ins.push_back(2'd2); exp_ins.push_back(2'd2);
    exp_wr.push_back(3'd3);  exp_wr.push_back(3'd7);
    drive_axon(4'd5, {3'd0, 3'd0, 3'd7, 3'd3}, 2, 0, 0, cyc, rs, to);
    checks++;
    if (to) begin errors++; $display("FAIL integrate timeout: got timeout want completion"); end
    checks++;
    if (rs !== 1) begin errors++; $display("FAIL read_spike pulse: got %0d cycles want 1", rs); end
    checks++;
    if (axon_number_out !== 4'd5) begin
      errors++; $display("FAIL axon_number_out: got %0d want 5", axon_number_out);
    end
    checks++;
    if (cyc !== 9) begin errors++; $display("FAIL integrate busy cycles: got %0d want 9", cyc); end
    checks++;
    if (exp_wr.size() != 0 || exp_ins.size() != 0) begin
      errors++;
      $display("FAIL integrate missing: writes left %0d instr left %0d want 0 0",
               exp_wr.size(), exp_ins.size());
    end
  endtask

  task automatic test_done_priority();
    int cyc, rs;
    bit to;
    exp_ins.push_back(2'd3);
    exp_wr.push_back(3'd1);
    drive_axon(4'd9, {3'd0, 3'd0, 3'd0, 3'd1}, 1, 0, 1, cyc, rs, to);
    repeat (3) @(negedge clk);
    checks++;
    if (to) begin errors++; $display("FAIL done_priority timeout: got timeout want idle"); end
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL done_priority cycles: got %0d want 5", cyc); end
    checks++;
    if (CSRAM_addr !== 3'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_priority state: addr=%0d busy=%b want 1 0", CSRAM_addr, busy);
    end
    checks++;
    if (exp_wr.size() != 0 || exp_ins.size() != 0) begin
      errors++; $display("FAIL done_priority missing: writes left %0d want 0", exp_wr.size());
    end
  endtask

  task automatic test_sweep_common(input int stall, input string nm);
    int bcyc, unst, wst, lkc;
    bit to;
    fire_mask = 8'h40;
    for (int i = 0; i < int'(NN); i++) exp_wr.push_back(NW'(i));
    exp_sp.push_back(3'd6);
    run_sweep(stall, 0, 1, bcyc, unst, wst, lkc, to);
    fire_mask = '0;
    checks++;
    if (to) begin errors++; $display("FAIL %s timeout: got timeout want completion", nm); end
    checks++;
    if (bcyc !== 3 * int'(NN) + 1 + stall) begin
      errors++; $display("FAIL %s busy cycles: got %0d want %0d", nm, bcyc, 3 * NN + 1 + stall);
    end
    checks++;
    if (unst !== 0 || wst !== 0) begin
      errors++; $display("FAIL %s stall: unstable=%0d writes=%0d want 0 0", nm, unst, wst);
    end
    checks++;
    if (lkc !== int'(NN)) begin
      errors++; $display("FAIL %s leak_en cycles: got %0d want %0d", nm, lkc, NN);
    end
    checks++;
    if (exp_wr.size() != 0 || exp_sp.size() != 0 || CSRAM_addr !== '0) begin
      errors++;
      $display("FAIL %s end: writes left %0d spikes left %0d addr=%0d want 0 0 0",
               nm, exp_wr.size(), exp_sp.size(), CSRAM_addr);
    end
  endtask

  task automatic test_sweep();
    test_sweep_common(0, "sweep");
    checks++;
    if (tick_overrun !== 1'b0) begin
      errors++; $display("FAIL sweep overrun: got %b want 0", tick_overrun);
    end
  endtask

  task automatic test_backpressure();
    test_sweep_common(10, "backpressure");
  endtask

  task automatic test_tick_during_integration();
    int cyc, rs, bcyc, unst, wst, lkc, extra;
    bit to;
    exp_ins.push_back(2'd3); exp_ins.push_back(2'd3);
    exp_wr.push_back(3'd3);  exp_wr.push_back(3'd4);
    for (int i = 0; i < int'(NN); i++) exp_wr.push_back(NW'(i));
    drive_axon(4'd9, {3'd0, 3'd0, 3'd4, 3'd3}, 2, 1, 0, cyc, rs, to);
    checks++;
    if (to || cyc !== 9) begin
      errors++; $display("FAIL tick_int axon: timeout=%b cycles=%0d want 0 9", to, cyc);
    end
    checks++;
    if (tick_overrun !== 1'b0) begin
      errors++; $display("FAIL tick_int overrun early: got %b want 0", tick_overrun);
    end
    run_sweep(0, 5, 0, bcyc, unst, wst, lkc, to);
    checks++;
    if (to || bcyc !== 3 * int'(NN)) begin
      errors++; $display("FAIL tick_int sweep: timeout=%b cycles=%0d want 0 %0d", to, bcyc, 3 * NN);
    end
    checks++;
    if (tick_overrun !== 1'b1) begin
      errors++; $display("FAIL tick_int overrun: got %b want 1", tick_overrun);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) extra++;
    end
    checks++;
    if (extra !== 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL tick_int single sweep: extra busy=%0d writes left %0d want 0 0",
               extra, exp_wr.size());
    end
  endtask

  task automatic test_reset_mid_spike();
    int guard, cyc, rs;
    bit to;
    fire_mask       = 8'h40;
    spike_out_ready = 1'b0;
    for (int i = 0; i < int'(NN); i++) exp_wr.push_back(NW'(i));
    exp_sp.push_back(3'd6);
    tick = 1'b1;
    @(negedge clk);
    tick  = 1'b0;
    guard = 0;
    while (!spike_out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (spike_out_valid !== 1'b1 || spike_out_neuron !== 3'd6) begin
      errors++;
      $display("FAIL rst_spike held: valid=%b neuron=%0d want 1 6", spike_out_valid,
               spike_out_neuron);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (spike_out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_spike async valid: got %b want 0", spike_out_valid);
    end
    checks++;
    if (busy !== 1'b0 || CSRAM_write !== 1'b0 || tick_overrun !== 1'b0) begin
      errors++;
      $display("FAIL rst_spike async state: busy=%b wr=%b ovr=%b want 0 0 0", busy,
               CSRAM_write, tick_overrun);
    end
    exp_wr.delete(); exp_sp.delete(); exp_ins.delete();
    @(negedge clk);
    rst = 1'b1;
    spike_out_ready = 1'b1;
    fire_mask = '0;
    exp_ins.push_back(2'd0);
    exp_wr.push_back(3'd4);
    drive_axon(4'd9, {3'd0, 3'd0, 3'd0, 3'd4}, 1, 0, 0, cyc, rs, to);
    checks++;
    if (to || exp_ins.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL rst_table cleared: timeout=%b instr left %0d writes left %0d want 0 0 0",
               to, exp_ins.size(), exp_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_config_integrate();
    test_done_priority();
    test_sweep();
    test_backpressure();
    test_tick_during_integration();
    test_reset_mid_spike();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
